seg2hex_rx: RTL

//  Receive side of the two-digit 7-segment display interface. Watches a time-multiplexed,

---
 rtl/seg2hex_rx_pkg.sv | 33 +++
 rtl/seg2hex_rx_decode.sv | 31 +++
 rtl/seg2hex_rx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg2hex_rx_pkg.sv
// rtl/seg2hex_rx_pkg.sv - shared 7-segment patterns, anode codes and FSM states for seg2hex_rx
package seg2hex_rx_pkg;

  // Active-low segments, bit6=g .. bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_NONE  = 2'b11;
  localparam logic [1:0] AN_BOTH  = 2'b00;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } rx_state_t;

  // tens*10+units without a multiplier; 99 fits in 7 bits
  function automatic logic [6:0] bcd_pair_value(input logic [3:0] tens, input logic [3:0] units);
    return ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, units};
  endfunction

endpackage

// File: rtl/seg2hex_rx_decode.sv
// rtl/seg2hex_rx_decode.sv - combinational 7-segment pattern to BCD digit decoder
module seg2hex_rx_decode
  import seg2hex_rx_pkg::*;
(
  input  logic [6:0] i_seg,
  input  logic       i_is_tens,
  output logic [3:0] o_digit,
  output logic       o_ok
);

  always_comb begin
    o_digit = 4'd0;
    o_ok    = 1'b1;
    case (i_seg)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      // Leading-zero blanking only makes sense on the tens digit
      SEG_BLANK: o_ok    = i_is_tens;
      default:   o_ok    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg2hex_rx.sv
// rtl/seg2hex_rx.sv - receive side of the two-digit 7-segment bus: digit FSM, frame stability, publish
module seg2hex_rx
  import seg2hex_rx_pkg::*;
#(
  parameter int SETTLE_CYC    = 4,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT_CYC   = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_seg,
  input  logic [1:0] i_an,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [3:0] o_tens,
  output logic [3:0] o_units,
  output logic [6:0] o_value,
  output logic       o_err,
  output logic       o_overrun,
  output logic       o_stale
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_an;
  logic [6:0]    r_seg;
  logic [3:0]    r_tens_slot, r_units_slot;
  logic          r_tens_ok, r_units_ok;
  logic          r_err;
  logic [7:0]    r_cand, r_last_pub;
  logic [SW-1:0] r_stable;
  logic          r_pub_seen;
  logic          r_valid, r_overrun, r_stale;
  logic [3:0]    r_tens, r_units;
  logic [6:0]    r_value;
  logic [TW-1:0] r_to_cnt;

  logic [3:0]    w_digit;
  logic          w_ok, w_restart, w_frame_done, w_publish;
  logic [7:0]    w_frame;
  logic [SW-1:0] w_next_stable;

  seg2hex_rx_decode u_decode (
    .i_seg     (r_seg),
    .i_is_tens (r_an == AN_TENS),
    .o_digit   (w_digit),
    .o_ok      (w_ok)
  );

  // WAIT, a change while settling, and an anode change in HOLD all re-evaluate i_an the same way
  assign w_restart = (r_state == S_WAIT) ||
                     ((r_state == S_SETTLE) && ((i_an != r_an) || (i_seg != r_seg))) ||
                     ((r_state == S_HOLD) && (i_an != r_an));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_WAIT;
      r_cnt        <= '0;
      r_an         <= AN_NONE;
      r_seg        <= SEG_BLANK;
      r_tens_slot  <= '0;
      r_units_slot <= '0;
      r_tens_ok    <= 1'b0;
      r_units_ok   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_an  <= i_an;
      r_seg <= i_seg;
      r_err <= 1'b0;
      if (w_frame_done) begin
        r_tens_ok  <= 1'b0;
        r_units_ok <= 1'b0;
      end
      if (w_restart) begin
        r_cnt <= CW'(1);
        case (i_an)
          AN_NONE: r_state <= S_WAIT;
          AN_BOTH: begin
            r_state <= S_WAIT;
            r_err   <= 1'b1;
          end
          default: r_state <= S_SETTLE;
        endcase
      end else if (r_state == S_SETTLE) begin
        if (r_cnt == CNT_LAST) begin
          r_state <= S_HOLD;
          if (!w_ok) begin
            r_err      <= 1'b1;
            r_tens_ok  <= 1'b0;
            r_units_ok <= 1'b0;
          end else if (r_an == AN_TENS) begin
            r_tens_slot <= w_digit;
            r_tens_ok   <= 1'b1;
          end else begin
            r_units_slot <= w_digit;
            r_units_ok   <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign w_frame_done  = r_tens_ok && r_units_ok;
  assign w_frame       = {r_tens_slot, r_units_slot};
  assign w_next_stable = (w_frame != r_cand)     ? SW'(1) :
                         (r_stable == STABLE_MAX) ? r_stable : r_stable + SW'(1);
  assign w_publish     = w_frame_done && (w_next_stable == STABLE_MAX) &&
                         (!r_pub_seen || (w_frame != r_last_pub));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cand     <= '0;
      r_stable   <= '0;
      r_last_pub <= '0;
      r_pub_seen <= 1'b0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_tens     <= '0;
      r_units    <= '0;
      r_value    <= '0;
      r_to_cnt   <= '0;
      r_stale    <= 1'b0;
    end else begin
      if (w_frame_done) begin
        r_cand   <= w_frame;
        r_stable <= w_next_stable;
      end
      if (w_publish) begin
        r_tens     <= r_tens_slot;
        r_units    <= r_units_slot;
        r_value    <= bcd_pair_value(r_tens_slot, r_units_slot);
        r_last_pub <= w_frame;
        r_pub_seen <= 1'b1;
        r_valid    <= 1'b1;
        r_overrun  <= r_valid && !i_ready;
      end else begin
        r_overrun <= 1'b0;
        if (r_valid && i_ready) r_valid <= 1'b0;
      end
      if (w_frame_done) begin
        r_to_cnt <= '0;
        r_stale  <= 1'b0;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + TW'(1);
        if (r_to_cnt == TO_LAST) r_stale <= 1'b1;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_tens    = r_tens;
  assign o_units   = r_units;
  assign o_value   = r_value;
  assign o_err     = r_err;
  assign o_overrun = r_overrun;
  assign o_stale   = r_stale;

endmodule
